// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encodings and control-bit indices for the pipeline skid stage
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam int CTRL_WB = 0;
  localparam int CTRL_MEM_R = 1;
  localparam int CTRL_MEM_W = 2;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: load-enabled payload register with synchronous active-low clear
module pipe_entry #(
  parameter int INSTR_W = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic [DATA_W-1:0]  result_in,
  output logic [INSTR_W-1:0] instr_q,
  output logic [CTRL_W-1:0]  ctrl_q,
  output logic [DATA_W-1:0]  result_q
);
  logic [INSTR_W-1:0] instr_d;
  logic [CTRL_W-1:0]  ctrl_d;
  logic [DATA_W-1:0]  result_d;
  always_comb begin
    instr_d = ld ? instr_in : instr_q;
    ctrl_d = ld ? ctrl_in : ctrl_q;
    result_d = ld ? result_in : result_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q <= '0;
      ctrl_q <= '0;
      result_q <= '0;
    end else begin
      instr_q <= instr_d;
      ctrl_q <= ctrl_d;
      result_q <= result_d;
    end
  end
endmodule

// File: rtl/exe_mem_pipe_skid.sv
// exe_mem_pipe_skid: EXE->MEM stage register with 2-entry skid, flush and saturating stall counter
module exe_mem_pipe_skid
  import pipe_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     instr_in,
  input  logic [CTRL_W-1:0]      ctrl_in,
  input  logic [DATA_W-1:0]      result_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [CTRL_W-1:0]      ctrl_out,
  output logic [DATA_W-1:0]      result_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic [1:0] state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic in_fire, out_fire, m_ld, m_from_s, s_ld;
  logic [INSTR_W-1:0] s_instr, m_instr_in;
  logic [CTRL_W-1:0] s_ctrl, m_ctrl, m_ctrl_in;
  logic [DATA_W-1:0] s_result, m_result_in;
  assign in_ready = state_q != ST_FULL;
  assign out_valid = state_q != ST_EMPTY;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    m_ld = 1'b0;
    m_from_s = 1'b0;
    s_ld = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        state_d = in_fire ? ST_BUSY : ST_EMPTY;
        m_ld = in_fire;
      end
      ST_BUSY: begin
        state_d = in_fire & !out_fire ? ST_FULL : (!in_fire & out_fire ? ST_EMPTY : ST_BUSY);
        m_ld = in_fire & out_fire;
        s_ld = in_fire & !out_fire;
      end
      ST_FULL: begin
        state_d = out_fire ? ST_BUSY : ST_FULL;
        m_ld = out_fire;
        m_from_s = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      m_ld = 1'b0;
      s_ld = 1'b0;
    end
    stall_cnt_d = out_valid & !out_ready & ~&stall_cnt_q ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_comb begin
    m_instr_in = m_from_s ? s_instr : instr_in;
    m_ctrl_in = m_from_s ? s_ctrl : ctrl_in;
    m_result_in = m_from_s ? s_result : result_in;
  end
  pipe_entry #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_m (
    .clk(clk), .rst(rst), .ld(m_ld),
    .instr_in(m_instr_in), .ctrl_in(m_ctrl_in), .result_in(m_result_in),
    .instr_q(instr_out), .ctrl_q(m_ctrl), .result_q(result_out)
  );
  pipe_entry #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_s (
    .clk(clk), .rst(rst), .ld(s_ld),
    .instr_in(instr_in), .ctrl_in(ctrl_in), .result_in(result_in),
    .instr_q(s_instr), .ctrl_q(s_ctrl), .result_q(s_result)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign ctrl_out = m_ctrl & {CTRL_W{out_valid}};
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_exe_mem_pipe_skid.sv
// tb_exe_mem_pipe_skid: random and directed stimulus against a 2-deep FIFO scoreboard model
module tb_exe_mem_pipe_skid;
  logic clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] instr_in = 0, result_in = 0;
  logic [2:0] ctrl_in = 0;
  logic in_ready, out_valid, in_ready4, out_valid4;
  logic [31:0] instr_out, result_out, instr_out4, result_out4;
  logic [2:0] ctrl_out, ctrl_out4;
  logic [15:0] stall_cnt;
  logic [3:0] stall_cnt4;
  typedef struct {
    logic [31:0] instr;
    logic [2:0] ctrl;
    logic [31:0] result;
  } ent_t;
  ent_t q[$];
  int scnt, checks, failures;
  bit armed, rchk;
  always #5 clk = ~clk;
  exe_mem_pipe_skid dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .ctrl_in(ctrl_in), .result_in(result_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .ctrl_out(ctrl_out), .result_out(result_out), .stall_cnt(stall_cnt)
  );
  exe_mem_pipe_skid #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .instr_in(instr_in), .ctrl_in(ctrl_in), .result_in(result_in), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .instr_out(instr_out4),
    .ctrl_out(ctrl_out4), .result_out(result_out4), .stall_cnt(stall_cnt4)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    bit ov, ifire;
    ov = q.size() > 0;
    if (armed) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, ov});
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      chk("ctrl_out", {61'd0, ctrl_out}, ov ? {61'd0, q[0].ctrl} : 64'd0);
      chk("stall_cnt16", {48'd0, stall_cnt}, scnt > 65535 ? 64'd65535 : 64'(scnt));
      chk("stall_cnt4", {60'd0, stall_cnt4}, scnt > 15 ? 64'd15 : 64'(scnt));
      chk("out_valid4", {63'd0, out_valid4}, {63'd0, ov});
      if (rchk) begin
        chk("reset_instr", {32'd0, instr_out}, 64'd0);
        chk("reset_result", {32'd0, result_out}, 64'd0);
      end
      if (ov && out_ready) begin
        chk("instr_out", {32'd0, instr_out}, {32'd0, q[0].instr});
        chk("result_out", {32'd0, result_out}, {32'd0, q[0].result});
      end
    end
    rchk = 0;
    if (!rst) begin
      q.delete();
      scnt = 0;
      rchk = 1;
      armed = 1;
    end else if (armed) begin
      if (ov && !out_ready) scnt++;
      ifire = in_valid && q.size() < 2;
      if (ov && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (ifire) q.push_back('{instr_in, ctrl_in, result_in});
    end
  end
  task automatic drive(input bit r, input bit iv, input logic [31:0] res, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    rst = r;
    in_valid = iv;
    instr_in = $urandom;
    ctrl_in = 3'($urandom_range(0, 7));
    result_in = res;
    out_ready = ordy;
    flush = fl;
  endtask
  initial begin
    repeat (2) drive(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    for (int k = 1; k <= 8; k++) drive(1, 1, 32'(k), 1, 0);
    repeat (3) drive(1, 0, 0, 1, 0);
    drive(1, 1, 32'hA, 0, 0);
    drive(1, 1, 32'hB, 0, 0);
    drive(1, 1, 32'hC, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0);
    repeat (4) drive(1, 0, 0, 1, 0);
    drive(1, 1, 32'hA, 0, 0);
    drive(1, 1, 32'hB, 0, 0);
    drive(1, 1, 32'hC, 0, 1);
    repeat (4) drive(1, 1, 32'hD, 1, 0);
    repeat (3) drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 32'h5, 0, 0);
    repeat (20) drive(1, 0, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 1, 0);
    drive(1, 1, 32'hA, 0, 0);
    drive(1, 1, 32'hB, 0, 0);
    drive(0, 1, 32'hE, 1, 0);
    repeat (2) drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 49) != 0, 1'($urandom), $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
    repeat (2) drive(1, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
